// File: rtl/playback_vector_engine.sv
// ============================================================================
// playback_vector_engine
//
// On-chip stimulus/expect engine. Stimulus, expected and care-mask vectors
// are loaded into internal RAM, then played back one vector per clock into a
// DUT input bus. The DUT output bus is compared against the masked
// expectation OUT_LAT cycles after each vector is applied, and the engine
// reports the mismatch count, the first failing index and its failing bits.
//
// Optional build macro: PLAYBACK_MM_LOG_EN
//   When defined, adds an 8-entry FIFO of mismatching vector indices
//   (mm_log_pop / mm_log_idx / mm_log_vld) with a sticky overflow flag
//   (mm_log_ovf) that clears on start.
//
// Ports
//   clk, arst_l        clock, asynchronous active-low reset
//   ld_stim_we         write ld_stim_data to stimulus RAM at ld_addr
//   ld_exp_we          write ld_exp_data / ld_mask_data at ld_addr
//   ld_addr            load address (AW bits)
//   ld_stim_data       stimulus word (IN_W)
//   ld_exp_data        expected word (OUT_W)
//   ld_mask_data       care mask, 1 = compare this bit (OUT_W)
//   start              begin playback (single-cycle pulse)
//   num_vec            vector count (AW+1 bits), sampled on start
//   halt_on_mm         stop at first mismatch, sampled on start
//   dut_in             registered stimulus to the DUT (IN_W)
//   dut_out            DUT response (OUT_W)
//   busy               in RUN or DRAIN
//   done               playback finished, held until the next start
//   pass               done and mm_cnt == 0
//   mm_cnt             mismatching vectors, saturating (CNT_W)
//   first_mm_idx       index of the first mismatching vector (AW)
//   first_mm_diff      (dut_out ^ exp) & mask of the first mismatch (OUT_W)
// ============================================================================
module playback_vector_engine #(
    parameter int IN_W    = 270,
    parameter int OUT_W   = 198,
    parameter int DEPTH   = 1024,
    parameter int OUT_LAT = 1,
    parameter int SKIP    = 2,
    parameter int CNT_W   = 16,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             arst_l,
    input  logic             ld_stim_we,
    input  logic             ld_exp_we,
    input  logic [AW-1:0]    ld_addr,
    input  logic [IN_W-1:0]  ld_stim_data,
    input  logic [OUT_W-1:0] ld_exp_data,
    input  logic [OUT_W-1:0] ld_mask_data,
    input  logic             start,
    input  logic [AW:0]      num_vec,
    input  logic             halt_on_mm,
    output logic [IN_W-1:0]  dut_in,
    input  logic [OUT_W-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] mm_cnt,
    output logic [AW-1:0]    first_mm_idx,
`ifdef PLAYBACK_MM_LOG_EN
    input  logic             mm_log_pop,
    output logic [AW-1:0]    mm_log_idx,
    output logic             mm_log_vld,
    output logic             mm_log_ovf,
`endif
    output logic [OUT_W-1:0] first_mm_diff
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t state_q, state_d;

    logic [IN_W-1:0]  stim_mem [DEPTH];
    logic [OUT_W-1:0] exp_mem  [DEPTH];
    logic [OUT_W-1:0] mask_mem [DEPTH];

    logic             start_ok;
    logic             nv_zero;
    logic [AW:0]      nv_clamp;
    logic [AW:0]      nv_m1;
    logic [AW-1:0]    nv_last_q;
    logic [AW-1:0]    iss_idx_q;
    logic [AW-1:0]    iss_addr;
    logic             iss_v;
    logic             halt_q;
    logic             rd_v;
    logic [AW-1:0]    rd_idx;
    logic             cmp_v_q;
    logic [AW-1:0]    cmp_idx_q;
    logic [OUT_W-1:0] exp_q;
    logic [OUT_W-1:0] mask_q;
    logic [OUT_W-1:0] cmp_diff;
    logic             mismatch;
    logic             cmp_fire;
    logic             halt_now;

    // ------------------------------------------------------------------
    // Status and control decode
    // ------------------------------------------------------------------
    assign busy     = (state_q == RUN) || (state_q == DRAIN);
    assign done     = (state_q == DONE);
    assign pass     = done && (mm_cnt == '0);

    assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));
    assign nv_zero  = (num_vec == '0);
    assign nv_clamp = (num_vec > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_vec;
    assign nv_m1    = nv_clamp - 1'b1;

    // Masking with AND forces don't-care bits to 0 even when dut_out is X.
    assign cmp_diff = (dut_out ^ exp_q) & mask_q;
    assign mismatch = (|cmp_diff) && (int'(cmp_idx_q) >= SKIP);
    assign cmp_fire = cmp_v_q && busy;
    assign halt_now = cmp_fire && mismatch && halt_q;

    // Index 0 is issued in the start cycle itself; RUN issues the rest.
    // A halting mismatch suppresses the issue so dut_in freezes.
    assign iss_v    = (start_ok && !nv_zero) || ((state_q == RUN) && !halt_now);
    assign iss_addr = (state_q == RUN) ? iss_idx_q : '0;

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    if (nv_zero)
                        state_d = DONE;
                    else if (nv_clamp == (AW+1)'(1))
                        state_d = DRAIN;
                    else
                        state_d = RUN;
                end
            end
            RUN: begin
                if (halt_now)
                    state_d = DONE;
                else if (iss_idx_q == nv_last_q)
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (halt_now)
                    state_d = DONE;
                else if (cmp_fire && (cmp_idx_q == nv_last_q))
                    state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            state_q   <= IDLE;
            iss_idx_q <= '0;
            nv_last_q <= '0;
            halt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                iss_idx_q <= AW'(1);
                nv_last_q <= nv_m1[AW-1:0];
                halt_q    <= halt_on_mm;
            end else if (state_q == RUN) begin
                iss_idx_q <= iss_idx_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Vector RAMs (loadable only while idle)
    // ------------------------------------------------------------------
    // NOTE: RAM arrays carry no reset; resetting them would prevent mapping
    // onto block RAM, and their contents are always written before use.
    always_ff @(posedge clk) begin
        if (ld_stim_we && !busy)
            stim_mem[ld_addr] <= ld_stim_data;
        if (ld_exp_we && !busy) begin
            exp_mem[ld_addr]  <= ld_exp_data;
            mask_mem[ld_addr] <= ld_mask_data;
        end
    end

    // Stimulus read register doubles as the dut_in output register.
    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l)
            dut_in <= '0;
        else if (iss_v)
            dut_in <= stim_mem[iss_addr];
    end

    // ------------------------------------------------------------------
    // Expect-side delay: only the index travels down the delay line; the
    // expect/mask RAMs are read at the end so the data arrives exactly in
    // the compare cycle (issue + 1 + OUT_LAT).
    // ------------------------------------------------------------------
    generate
        if (OUT_LAT == 0) begin : g_no_dly
            assign rd_v   = iss_v;
            assign rd_idx = iss_addr;
        end else begin : g_dly
            logic [OUT_LAT-1:0]         dly_v;
            logic [OUT_LAT-1:0][AW-1:0] dly_idx;

            always_ff @(posedge clk or negedge arst_l) begin
                if (!arst_l) begin
                    dly_v   <= '0;
                    dly_idx <= '0;
                end else begin
                    dly_v[0]   <= iss_v && !halt_now;
                    dly_idx[0] <= iss_addr;
                    for (int i = 1; i < OUT_LAT; i++) begin
                        dly_v[i]   <= dly_v[i-1] && !halt_now;
                        dly_idx[i] <= dly_idx[i-1];
                    end
                end
            end

            assign rd_v   = dly_v[OUT_LAT-1];
            assign rd_idx = dly_idx[OUT_LAT-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rd_v) begin
            exp_q  <= exp_mem[rd_idx];
            mask_q <= mask_mem[rd_idx];
        end
    end

    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            cmp_v_q   <= 1'b0;
            cmp_idx_q <= '0;
        end else begin
            cmp_v_q   <= rd_v && !halt_now;
            cmp_idx_q <= rd_idx;
        end
    end

    // ------------------------------------------------------------------
    // Result capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            mm_cnt        <= '0;
            first_mm_idx  <= '0;
            first_mm_diff <= '0;
        end else if (start_ok) begin
            mm_cnt        <= '0;
            first_mm_idx  <= '0;
            first_mm_diff <= '0;
        end else if (cmp_fire && mismatch) begin
            if (mm_cnt != '1)
                mm_cnt <= mm_cnt + 1'b1;
            if (mm_cnt == '0) begin
                first_mm_idx  <= cmp_idx_q;
                first_mm_diff <= cmp_diff;
            end
        end
    end

`ifdef PLAYBACK_MM_LOG_EN
    // ------------------------------------------------------------------
    // Mismatch index log: 8-entry FIFO, drops pushes when full.
    // ------------------------------------------------------------------
    logic [AW-1:0] log_mem [8];
    logic [2:0]    log_wr_q;
    logic [2:0]    log_rd_q;
    logic [3:0]    log_cnt_q;
    logic          log_push;
    logic          log_pop;
    logic          log_full;
    logic          log_push_ok;

    assign log_push    = cmp_fire && mismatch;
    assign log_pop     = mm_log_pop && (log_cnt_q != 4'd0);
    assign log_full    = (log_cnt_q == 4'd8);
    // A pop in the same cycle frees the slot the push needs.
    assign log_push_ok = log_push && (!log_full || log_pop);
    assign mm_log_vld  = (log_cnt_q != 4'd0);
    assign mm_log_idx  = log_mem[log_rd_q];

    always_ff @(posedge clk) begin
        if (log_push_ok)
            log_mem[log_wr_q] <= cmp_idx_q;
    end

    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            log_wr_q   <= '0;
            log_rd_q   <= '0;
            log_cnt_q  <= '0;
            mm_log_ovf <= 1'b0;
        end else if (start_ok) begin
            log_wr_q   <= '0;
            log_rd_q   <= '0;
            log_cnt_q  <= '0;
            mm_log_ovf <= 1'b0;
        end else begin
            if (log_push && !log_push_ok)
                mm_log_ovf <= 1'b1;
            if (log_push_ok)
                log_wr_q <= log_wr_q + 1'b1;
            if (log_pop)
                log_rd_q <= log_rd_q + 1'b1;
            log_cnt_q <= log_cnt_q + {3'b000, log_push_ok} - {3'b000, log_pop};
        end
    end
`endif

endmodule

// File: tb/tb_playback_vector_engine.sv
// ============================================================================
// tb_playback_vector_engine
//
// Self-checking bench for playback_vector_engine. The DUT behind the engine
// is a 1-cycle register computing dut_in[OUT_W-1:0] ^ KEY, with a per-vector
// corruption pattern XORed in (looked up by the vector index held in the low
// stimulus bits). A run-level model derives mismatch results, the done cycle
// and the dut_in sequence from the vector tables; each run is checked every
// cycle against it, plus literal expectations on selected runs.
// ============================================================================
module tb_playback_vector_engine;

    localparam int IN_W    = 270;
    localparam int OUT_W   = 198;
    localparam int DEPTH   = 1024;
    localparam int OUT_LAT = 1;
    localparam int SKIP    = 2;
    localparam int CNT_W   = 16;
    localparam int AW      = 10;
    localparam logic [OUT_W-1:0] KEY = {6{33'h1_2345_6789}};

    logic             clk = 1'b0;
    logic             arst_l = 1'b0;
    logic             ld_stim_we = 1'b0;
    logic             ld_exp_we = 1'b0;
    logic [AW-1:0]    ld_addr = '0;
    logic [IN_W-1:0]  ld_stim_data = '0;
    logic [OUT_W-1:0] ld_exp_data = '0;
    logic [OUT_W-1:0] ld_mask_data = '0;
    logic             start = 1'b0;
    logic [AW:0]      num_vec = '0;
    logic             halt_on_mm = 1'b0;
    logic [IN_W-1:0]  dut_in;
    logic [OUT_W-1:0] dut_out = '0;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] mm_cnt;
    logic [AW-1:0]    first_mm_idx;
    logic [OUT_W-1:0] first_mm_diff;
`ifdef PLAYBACK_MM_LOG_EN
    logic             mm_log_pop = 1'b0;
    logic [AW-1:0]    mm_log_idx;
    logic             mm_log_vld;
    logic             mm_log_ovf;
`endif

    playback_vector_engine #(
        .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH),
        .OUT_LAT(OUT_LAT), .SKIP(SKIP), .CNT_W(CNT_W)
    ) u_dut (
        .clk(clk),
        .arst_l(arst_l),
        .ld_stim_we(ld_stim_we),
        .ld_exp_we(ld_exp_we),
        .ld_addr(ld_addr),
        .ld_stim_data(ld_stim_data),
        .ld_exp_data(ld_exp_data),
        .ld_mask_data(ld_mask_data),
        .start(start),
        .num_vec(num_vec),
        .halt_on_mm(halt_on_mm),
        .dut_in(dut_in),
        .dut_out(dut_out),
        .busy(busy),
        .done(done),
        .pass(pass),
        .mm_cnt(mm_cnt),
        .first_mm_idx(first_mm_idx),
`ifdef PLAYBACK_MM_LOG_EN
        .mm_log_pop(mm_log_pop),
        .mm_log_idx(mm_log_idx),
        .mm_log_vld(mm_log_vld),
        .mm_log_ovf(mm_log_ovf),
`endif
        .first_mm_diff(first_mm_diff)
    );

    always #5 clk = ~clk;

    // Vector tables and per-vector corruption applied by the modelled DUT.
    logic [IN_W-1:0]  stim_m [DEPTH];
    logic [OUT_W-1:0] exp_m  [DEPTH];
    logic [OUT_W-1:0] mask_m [DEPTH];
    logic [OUT_W-1:0] corr   [DEPTH];

    always @(posedge clk)
        dut_out <= dut_in[OUT_W-1:0] ^ KEY ^ corr[dut_in[AW-1:0]];

    int checks = 0;
    int failures = 0;

    // Model results for the current run.
    int               e_mm;
    int               e_first;
    logic [OUT_W-1:0] e_diff;
    int               e_done_cyc;
    int               e_last;
    logic [IN_W-1:0]  e_din = '0;
    int               e_log[$];
    bit               e_ovf;
    int               obs_done;

    task automatic check(input string name, input logic [287:0] act, input logic [287:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wr_vec(input int n);
        @(posedge clk); #1;
        ld_stim_we   = 1'b1;
        ld_exp_we    = 1'b1;
        ld_addr      = AW'(n);
        ld_stim_data = stim_m[n];
        ld_exp_data  = exp_m[n];
        ld_mask_data = mask_m[n];
        @(posedge clk); #1;
        ld_stim_we = 1'b0;
        ld_exp_we  = 1'b0;
    endtask

    // Fresh random vectors 0..nv-1; low AW stimulus bits carry the index.
    task automatic prep(input int nv);
        logic [287:0] r;
        for (int n = 0; n < nv; n++) begin
            r = {$urandom, $urandom, $urandom, $urandom, $urandom,
                 $urandom, $urandom, $urandom, $urandom};
            stim_m[n] = r[IN_W-1:0];
            stim_m[n][AW-1:0] = AW'(n);
            exp_m[n]  = stim_m[n][OUT_W-1:0] ^ KEY;
            mask_m[n] = '1;
            corr[n]   = '0;
            @(posedge clk); #1;
            ld_stim_we   = 1'b1;
            ld_exp_we    = 1'b1;
            ld_addr      = AW'(n);
            ld_stim_data = stim_m[n];
            ld_exp_data  = exp_m[n];
            ld_mask_data = mask_m[n];
        end
        @(posedge clk); #1;
        ld_stim_we = 1'b0;
        ld_exp_we  = 1'b0;
    endtask

    // Run-level model: which vectors fail, when done rises, where dut_in stops.
    // Cycle 0 is the start cycle.
    task automatic model(input int nv_in, input bit halt);
        int nv;
        int h;
        logic [OUT_W-1:0] actual;
        logic [OUT_W-1:0] d;
        nv = (nv_in > DEPTH) ? DEPTH : nv_in;
        e_mm = 0; e_first = 0; e_diff = '0; h = -1;
        e_log.delete(); e_ovf = 1'b0;
        for (int n = 0; n < nv; n++) begin
            actual = stim_m[n][OUT_W-1:0] ^ KEY ^ corr[n];
            d = (actual ^ exp_m[n]) & mask_m[n];
            if (n >= SKIP && d != '0) begin
                if (e_mm == 0) begin
                    e_first = n;
                    e_diff  = d;
                end
                e_mm++;
                if (e_log.size() < 8) e_log.push_back(n);
                else e_ovf = 1'b1;
                if (halt) begin
                    h = n;
                    break;
                end
            end
        end
        if (nv == 0) begin
            e_done_cyc = 1;
            e_last = -1;
        end else if (h >= 0) begin
            e_done_cyc = h + 1 + OUT_LAT + 1;
            e_last = (h + 1 < nv - 1) ? h + 1 : nv - 1;
        end else begin
            e_done_cyc = nv + OUT_LAT + 1;
            e_last = nv - 1;
        end
    endtask

    // Start a run and check dut_in/busy/done every cycle up to one past done.
    // 'disturb' issues a second start and RAM writes while busy.
    task automatic run(input int nv_in, input bit halt, input bit disturb);
        int nv;
        model(nv_in, halt);
        nv = (nv_in > DEPTH) ? DEPTH : nv_in;
        @(posedge clk); #1;
        start      = 1'b1;
        num_vec    = (AW+1)'(nv_in);
        halt_on_mm = halt;
        obs_done   = -1;
        for (int k = 1; k <= e_done_cyc + 1; k++) begin
            @(posedge clk); #1;
            start      = 1'b0;
            ld_stim_we = 1'b0;
            ld_exp_we  = 1'b0;
            if (disturb && k == 2) begin
                start        = 1'b1;
                num_vec      = (AW+1)'(5);
                ld_stim_we   = 1'b1;
                ld_exp_we    = 1'b1;
                ld_addr      = AW'(1);
                ld_stim_data = ~stim_m[1];
                ld_exp_data  = ~exp_m[1];
                ld_mask_data = '1;
            end
            @(negedge clk);
            if (nv > 0)
                e_din = stim_m[(k - 1 < e_last) ? k - 1 : e_last];
            check("dut_in", dut_in, e_din);
            check("busy", busy, k < e_done_cyc);
            check("done", done, k >= e_done_cyc);
            if (done && obs_done < 0) obs_done = k;
        end
        check("mm_cnt", mm_cnt, e_mm);
        check("first_mm_idx", first_mm_idx, e_first);
        check("first_mm_diff", first_mm_diff, e_diff);
        check("pass", pass, e_mm == 0);
`ifdef PLAYBACK_MM_LOG_EN
        check("mm_log_vld", mm_log_vld, e_log.size() != 0);
        check("mm_log_ovf", mm_log_ovf, e_ovf);
        if (e_log.size() != 0)
            check("mm_log_head", mm_log_idx, e_log[0]);
`endif
    endtask

    initial begin
        for (int n = 0; n < DEPTH; n++) corr[n] = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_dut_in", dut_in, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_mm_cnt", mm_cnt, 0);
        check("rst_first_idx", first_mm_idx, 0);
        check("rst_first_diff", first_mm_diff, 0);
        @(negedge clk);
        arst_l = 1'b1;

        // Clean 4-vector run: done in cycle 6
        prep(4);
        run(4, 1'b0, 1'b0);
        check("lit_done_cyc4", obs_done, 6);
        check("lit_pass_clean", pass, 1);

        // Bit 5 corrupted on vector 2
        corr[2] = OUT_W'(1) << 5;
        run(4, 1'b0, 1'b0);
        check("lit_mm_cnt1", mm_cnt, 1);
        check("lit_first_idx2", first_mm_idx, 2);
        check("lit_first_diff20", first_mm_diff, 'h20);
        check("lit_fail", pass, 0);

        // Same corruption plus another bit, both masked off
        corr[2] = (OUT_W'(1) << 5) | (OUT_W'(1) << 100);
        mask_m[2][5]   = 1'b0;
        mask_m[2][100] = 1'b0;
        wr_vec(2);
        run(4, 1'b0, 1'b0);
        check("lit_masked_pass", pass, 1);

        // Corruption on a skipped vector; start and loads while busy ignored
        corr[2] = '0;
        mask_m[2] = '1;
        wr_vec(2);
        corr[1] = OUT_W'(1) << 7;
        run(4, 1'b0, 1'b1);
        check("lit_skip_pass", pass, 1);
        run(4, 1'b0, 1'b0);

        // Halt on first mismatch of vectors 3 and 5
        prep(8);
        corr[3] = OUT_W'(1);
        corr[5] = OUT_W'(1) << 197;
        run(8, 1'b1, 1'b0);
        check("lit_halt_done_cyc", obs_done, 6);
        check("lit_halt_mm_cnt", mm_cnt, 1);
        check("lit_halt_frozen", dut_in, stim_m[4]);

        // Same vectors without halt
        run(8, 1'b0, 1'b0);
        check("lit_nohalt_mm_cnt", mm_cnt, 2);
        check("lit_nohalt_diff", first_mm_diff, 1);

        // num_vec == 0 from a failing DONE
        run(0, 1'b0, 1'b0);
        check("lit_zero_done_cyc", obs_done, 1);
        check("lit_zero_pass", pass, 1);

        // Full depth, clamped count and exact count; mismatch on the last index
        prep(DEPTH);
        corr[DEPTH-1] = OUT_W'(1) << 50;
        run(2047, 1'b0, 1'b0);
        check("lit_clamp_done_cyc", obs_done, DEPTH + 2);
        check("lit_clamp_first_idx", first_mm_idx, DEPTH - 1);
        run(DEPTH, 1'b0, 1'b0);
        check("lit_full_mm_cnt", mm_cnt, 1);

        // Reset in the middle of a 16-vector run
        corr[DEPTH-1] = '0;
        corr[3] = OUT_W'(1) << 9;
        @(posedge clk); #1;
        start      = 1'b1;
        num_vec    = (AW+1)'(16);
        halt_on_mm = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        check("pre_rst_busy", busy, 1);
        check("pre_rst_mm_cnt", mm_cnt, 1);
        arst_l = 1'b0;
        #1;
        check("mid_rst_dut_in", dut_in, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_pass", pass, 0);
        check("mid_rst_mm_cnt", mm_cnt, 0);
        check("mid_rst_first_idx", first_mm_idx, 0);
        check("mid_rst_first_diff", first_mm_diff, 0);
        e_din = '0;
        @(negedge clk);
        arst_l = 1'b1;
        @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_done", done, 0);
        run(4, 1'b0, 1'b0);
        check("lit_post_rst_idx", first_mm_idx, 3);

`ifdef PLAYBACK_MM_LOG_EN
        // 10 mismatches, no pops: log keeps the first 8 and flags overflow
        prep(12);
        for (int n = 2; n < 12; n++) corr[n] = OUT_W'(1) << 1;
        run(12, 1'b0, 1'b0);
        check("lit_log_mm_cnt", mm_cnt, 10);
        check("lit_log_ovf", mm_log_ovf, 1);
        @(posedge clk); #1;
        mm_log_pop = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("log_pop_vld", mm_log_vld, 1);
            check("log_pop_idx", mm_log_idx, 2 + i);
            @(posedge clk); #1;
        end
        mm_log_pop = 1'b0;
        @(negedge clk);
        check("log_empty_vld", mm_log_vld, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
